// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arbState_t        : arbiter FSM states
//   OWNER_*           : encoding of the 'owner' status output
//   MAX_WAIT_DEFAULT  : default number of consecutive data grants that may
//                       pass a pending instruction request
package mem_arb_pkg;

  localparam int MAX_WAIT_DEFAULT = 4;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_I    = 2'd1;
  localparam logic [1:0] OWNER_D    = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one backing memory between an instruction-fetch
// requester and a load/store requester. Data wins ties, except that after
// MAX_WAIT consecutive data grants with the instruction side waiting, the
// instruction side is served next.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   i_req, i_addr                : instruction read request / word address
//   i_rdata, i_done              : instruction read data, one-cycle completion
//   d_req, d_we, d_addr, d_wdata : data request, write enable, address, data
//   d_rdata, d_done              : data read data, one-cycle completion
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    : backing-memory request (held until ack)
//   mem_rdata, mem_ack           : backing-memory response
//   owner                        : 0 none, 1 instruction, 2 data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arbState_t        state;
  logic [CNT_W-1:0] waitCnt;

  // Instruction side is served when it is alone or has been starved long enough.
  logic grantI;
  logic grantD;

  always_comb begin
    grantI = i_req && (!d_req || (waitCnt == WAIT_LIMIT));
    grantD = d_req && !grantI;
  end

  // The memory-side outputs double as the latched request: they are loaded
  // at the grant edge and stay frozen until the acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      owner     <= OWNER_NONE;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req) begin
            waitCnt <= '0;
          end
          if (grantI) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            owner     <= OWNER_I;
            waitCnt   <= '0;
          end else if (grantD) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            owner     <= OWNER_D;
            // Only count data grants that made the instruction side wait.
            if (i_req && (waitCnt != WAIT_LIMIT)) begin
              waitCnt <= waitCnt + CNT_W'(1);
            end
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state   <= RESP;
            i_rdata <= mem_rdata;
            i_done  <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state   <= RESP;
            d_rdata <= mem_rdata;
            d_done  <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= OWNER_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: number of consecutive data-side grants allowed while the instruction side is pending; range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  instruction-side read request, held high until i_done.
REQ-005 i_addr  input  32  instruction-side word address.
REQ-006 i_rdata  output  32  instruction-side read data, valid while i_done=1.
REQ-007 i_done  output  1  one-cycle completion pulse, instruction side.
REQ-008 d_req  input  1  data-side request, held high until d_done.
REQ-009 d_we  input  1  data-side write enable (1 = store).
REQ-010 d_addr  input  32  data-side word address.
REQ-011 d_wdata  input  32  data-side write data.
REQ-012 d_rdata  output  32  data-side read data, valid while d_done=1.
REQ-013 d_done  output  1  one-cycle completion pulse, data side.
REQ-014 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-015 mem_we  output  1  backing-memory write enable.
REQ-016 mem_addr  output  32  backing-memory address.
REQ-017 mem_wdata  output  32  backing-memory write data.
REQ-018 mem_rdata  input  32  backing-memory read data, valid with mem_ack.
REQ-019 mem_ack  input  1  backing-memory completion, single cycle, arbitrary latency >= 1.
REQ-020 owner  output  2  current owner: 0 none, 1 instruction, 2 data.

Function
REQ-021 FSM states SHALL be IDLE, BUSY_I, BUSY_D and RESP.
REQ-022 Requests SHALL be sampled only in IDLE; in all other states req lines are ignored.
REQ-023 In IDLE with only i_req high, the FSM SHALL go to BUSY_I; with only d_req high, it SHALL go to BUSY_D.
REQ-024 In IDLE with both requests high, data SHALL win unless wait_cnt == MAX_WAIT, in which case instruction SHALL win.
REQ-025 At the grant edge, address, write enable and write data SHALL be latched; requester input changes during BUSY or RESP SHALL have no effect.
REQ-026 In BUSY_I and BUSY_D, mem_req SHALL be 1 and driven from the latched values; mem_we SHALL always be 0 in BUSY_I.
REQ-027 On mem_ack in BUSY_x, mem_rdata SHALL be registered into x_rdata and the FSM SHALL go to RESP.
REQ-028 In RESP, the matching x_done SHALL be 1 for exactly one cycle, mem_req SHALL be 0, and the FSM SHALL then go to IDLE.
REQ-029 Minimum latency SHALL be: req seen in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ack at cycle k >= 1 -> done at cycle k+1 -> IDLE at cycle k+2.
REQ-030 A req high in the IDLE cycle after RESP SHALL be treated as a new request; requesters drop req at the edge ending their done cycle.
REQ-031 wait_cnt SHALL increment, saturating at MAX_WAIT, on each data grant made while i_req is high.
REQ-032 wait_cnt SHALL clear on any instruction grant, and in any IDLE cycle with i_req low.
REQ-033 mem_ack outside BUSY_I or BUSY_D SHALL be ignored.
REQ-034 i_rdata and d_rdata SHALL hold their last value between done pulses.
REQ-035 owner SHALL be 1 in BUSY_I and in RESP following BUSY_I, 2 in BUSY_D and in RESP following BUSY_D, and 0 in IDLE.

Reset
REQ-036 On rst: state IDLE, wait_cnt 0, mem_req/mem_we/i_done/d_done 0, owner 0, and all data and address registers 0.
REQ-037 rst during BUSY or RESP SHALL abandon the transaction; no done pulse SHALL be issued, and a late mem_ack SHALL be ignored per REQ-033.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY_I, BUSY_D, RESP), the owner encoding constants and the MAX_WAIT default.
REQ-039 The block SHALL be a single module with no sub-module; wait_cnt width is $clog2(MAX_WAIT+1).

Verification
REQ-040 Stimulus: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, d_done at cycle 4, i_done stays 0.
REQ-041 Stimulus: i_req with i_addr=0x40, mem_rdata=0x00500093 on ack -> i_rdata=0x00500093 with a single i_done pulse; mem_we=0 throughout.
REQ-042 Stimulus: both requests held continuously, MAX_WAIT=4, ack latency 1 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-043 Stimulus: i_addr changed from 0x40 to 0x80 during BUSY_I -> mem_addr stays 0x40 until ack.
REQ-044 Stimulus: rst asserted in BUSY_D, then mem_ack one cycle after rst releases -> no d_done, owner=0, mem_req=0.
REQ-045 Stimulus: d_req reasserted in the IDLE cycle right after d_done, with i_req low -> second transaction granted and wait_cnt stays 0.
